bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Arbitrates ownership of the shared Z80 master bus among MASTER_QTY masters and drives the
//  msel select of the master mux directly downstream. Master PARK_MASTER (the CPU) owns the
//  bus by default and yields to any other requester. Ownership changes only when the muxed bus
//  is idle, with a programmable dead gap. Non-park requesters are served round-robin.
// PARAMETERS
//  MASTER_QTY      2  number of masters (>=1)
//  PARK_MASTER     0  default owner; its req bit is ignored (implicit permanent request)
//  HANDOFF_CYCLES  1  dead cycles with no grant between owners (0 = no gap)
//  MAX_HOLD        0  cycles a non-park owner may hold before rel_req (0 = unlimited)
// PORTS
//  clk      in   1      system clock
//  rst      in   1      synchronous reset, active-high
//  req      in   MQ     per-master bus request, level, held for the whole tenure
//  bus_mon  in   Z80MasterBus  muxed master bus (master-mux output); idle = rdn & wrn
//  gnt      out  MQ     one-hot grant, or all-zero in GAP; registered
//  msel     out  CLAMP_LOW($clog2(MQ)-1,0)+1  master-mux select; registered
//  rel_req  out  1      asks current non-park owner to finish and drop req; registered
//  owner    out  same as msel  current or next owner, for debug/status
// BEHAVIOUR
//  Reset (rst sampled high): state=OWN, owner=msel=PARK_MASTER, gnt=onehot(PARK_MASTER),
//   rel_req=0, hold counter=0. Reset mid-tenure or mid-gap aborts immediately, with no drain.
//  OWN: gnt=onehot(owner), msel=owner.
//   - owner==PARK and any req[i] (i!=PARK) high -> DRAIN.
//   - owner!=PARK and req[owner] low -> DRAIN.
//   - owner!=PARK: hold counter counts cycles in OWN (saturating); when count>=MAX_HOLD
//     (MAX_HOLD!=0) and another non-park req is high, rel_req=1 until leaving OWN. The arbiter
//     never revokes; the owner must drop req.
//  DRAIN: gnt still asserted. On the first cycle bus_mon.rdn & bus_mon.wrn both sample high:
//   - pick next = first req[i] high, i!=PARK, searching owner+1, owner+2, ... (mod MQ);
//     if none -> next=PARK.
//   - if next==owner (park, no requests left) -> back to OWN, no gap.
//   - else owner<=next, msel<=next, gnt<=0 -> GAP (or OWN directly if HANDOFF_CYCLES==0).
//  GAP: gnt=0, msel=new owner, and a down-counter runs HANDOFF_CYCLES cycles. At expiry:
//   - if owner==PARK or req[owner] still high -> OWN.
//   - otherwise re-pick as in DRAIN (fallback PARK) and go to OWN without a second gap.
//  Latency: req sampled high at edge k with park owner and bus idle -> DRAIN at k+1 ->
//   GAP at k+2 -> gnt[i] high after edge k+2+HANDOFF_CYCLES.
//  Simultaneous requests: round-robin pointer = last non-park owner. After reset the search
//   starts from PARK_MASTER+1.
//  Requests that rise while in DRAIN or GAP are considered only at the next pick point.
//  MASTER_QTY==1: constant OWN, gnt=1, msel=0, rel_req=0. req and bus_mon are ignored.
//  Invariant: gnt has at most one bit set, and any set bit equals msel.
// STRUCTURE
//  Shared package z80_sys_pkg: arb_state_t enum {ARB_OWN, ARB_DRAIN, ARB_GAP}, and the
//   CLAMP_LOW width helper as a function. Z80MasterBus comes from Z80Bus.vh.
//  Sub-module rr_pick #(N): combinational round-robin search (req, start ptr, exclude idx)
//   -> {found, idx}. Reused by both pick points.
// TESTING
//  1. MQ=3, H=1: after rst, gnt=3'b001, msel=0; raise req[2] with bus idle -> gnt=000 for 1
//     cycle, then gnt=100, msel=2 at cycle 3 after req.
//  2. Hold bus_mon.rdn=0 for 5 cycles while req[1] is high -> gnt stays 001 through the 5
//     cycles; handoff starts on the first idle cycle.
//  3. req[1] and req[2] rise together, and each drops 4 cycles after its grant -> grant order
//     1,2; repeat -> order 1,2 again (pointer wrap), with park between tenures.
//  4. MAX_HOLD=3, owner 1, req[2] high -> rel_req=1 after 3 owner cycles; drop req[1] ->
//     drain, gap, gnt=100.
//  5. req[2] drops during GAP with no other requester -> OWN with owner=0, gnt=001, no second gap.
//  6. rst asserted mid-GAP and mid-OWN(owner 2) -> next cycle gnt=001, msel=0, rel_req=0.
//     Check the one-hot/msel invariant every cycle.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding, monitored bus type and width helper
package bus_arbiter_pkg;
   typedef enum logic [1:0] {ARB_OWN, ARB_DRAIN, ARB_GAP} arb_state_t;
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  dout;
      logic        mreqn;
      logic        iorqn;
      logic        m1n;
      logic        rdn;
      logic        wrn;
   } z80_master_bus_t;
   function automatic int clamp_low(input int v, input int lo);
      return v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the masters, the arbiter and the master mux
//   req      masters -> arbiter, level request per master
//   bus_mon  muxed master bus seen by the arbiter; idle when rdn & wrn
//   gnt      one-hot grant (all zero during the handoff gap)
//   msel     master-mux select
//   rel_req  asks the current non-park owner to finish its tenure
//   owner    current or upcoming owner, for status
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int MASTER_QTY = 2
);
   localparam int W = clamp_low($clog2(MASTER_QTY) - 1, 0) + 1;
   logic [MASTER_QTY-1:0] req;
   logic [MASTER_QTY-1:0] gnt;
   z80_master_bus_t       bus_mon;
   logic [W-1:0]          msel;
   logic [W-1:0]          owner;
   logic                  rel_req;
   modport master (input req, bus_mon, output gnt, msel, rel_req, owner);
   modport slave  (output req, bus_mon, input gnt, msel, rel_req, owner);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick: first request after start_i (wrapping, start_i itself last), skipping excl_i
//   req_i    request vector
//   start_i  round-robin pointer; search begins at start_i+1
//   excl_i   index never picked (the park master)
//   found_o  a request was found
//   idx_o    picked index (excl_i when none found)
module bus_arbiter_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
)(
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   input  logic [W-1:0] excl_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);
   always_comb begin
      found_o = 1'b0;
      idx_o   = excl_i;
      // Walk from the far end so the nearest candidate overwrites the rest.
      for (int k = N; k >= 1; k--) begin
         if (req_i[(int'(start_i) + k) % N] && ((int'(start_i) + k) % N) != int'(excl_i)) begin
            found_o = 1'b1;
            idx_o   = W'((int'(start_i) + k) % N);
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: parked round-robin ownership of the shared master bus with idle-gated handoff
//   clk     system clock
//   rst     synchronous reset, active high
//   arb_io  master modport of bus_arbiter_if (req/bus_mon in; gnt/msel/rel_req/owner out)
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MASTER_QTY     = 2,
   parameter int PARK_MASTER    = 0,
   parameter int HANDOFF_CYCLES = 1,
   parameter int MAX_HOLD       = 0
)(
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.master arb_io
);
   localparam int W = clamp_low($clog2(MASTER_QTY) - 1, 0) + 1;
   if (MASTER_QTY == 1) begin : g_single
      assign arb_io.gnt     = 1'b1;
      assign arb_io.msel    = '0;
      assign arb_io.owner   = '0;
      assign arb_io.rel_req = 1'b0;
   end else begin : g_multi
      localparam int                    HW       = clamp_low($clog2(HANDOFF_CYCLES + 1), 1);
      localparam logic [W-1:0]          PARK     = W'(PARK_MASTER);
      localparam logic [MASTER_QTY-1:0] PARK_OH  = MASTER_QTY'(1) << PARK_MASTER;
      localparam logic [HW-1:0]         GAP_LOAD = HW'(HANDOFF_CYCLES > 0 ? HANDOFF_CYCLES - 1 : 0);
      arb_state_t            state_q;
      logic [W-1:0]          owner_q, msel_q, rr_q, pick_idx, next;
      logic [MASTER_QTY-1:0] gnt_q, others, owner_oh, next_oh;
      logic [HW-1:0]         gap_q;
      logic [31:0]           hold_q, hold_d;
      logic                  rel_q, pick_found, idle, own_leave, keep, hold_hit;
      // The pointer is the last non-park owner, so one search serves both pick points.
      bus_arbiter_rr_pick #(.N(MASTER_QTY), .W(W)) u_pick (
         .req_i   (arb_io.req),
         .start_i (rr_q),
         .excl_i  (PARK),
         .found_o (pick_found),
         .idx_o   (pick_idx)
      );
      always_comb begin
         idle      = arb_io.bus_mon.rdn & arb_io.bus_mon.wrn;
         others    = arb_io.req & ~PARK_OH;
         owner_oh  = MASTER_QTY'(1) << owner_q;
         next      = pick_found ? pick_idx : PARK;
         next_oh   = MASTER_QTY'(1) << next;
         own_leave = owner_q == PARK ? |others : !arb_io.req[owner_q];
         keep      = owner_q == PARK || arb_io.req[owner_q];
         hold_d    = &hold_q ? hold_q : hold_q + 32'd1;
         hold_hit  = owner_q != PARK && MAX_HOLD != 0 && hold_d >= 32'(MAX_HOLD) && |(others & ~owner_oh);
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ARB_OWN;
            owner_q <= PARK;
            msel_q  <= PARK;
            rr_q    <= PARK;
            gnt_q   <= PARK_OH;
            rel_q   <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
         end else begin
            rel_q  <= 1'b0;
            hold_q <= '0;
            case (state_q)
               ARB_OWN: begin
                  if (own_leave) state_q <= ARB_DRAIN;
                  else begin
                     hold_q <= hold_d;
                     rel_q  <= rel_q | hold_hit;
                  end
               end
               ARB_DRAIN: begin
                  if (idle && next == owner_q) state_q <= ARB_OWN;
                  else if (idle) begin
                     owner_q <= next;
                     msel_q  <= next;
                     if (next != PARK) rr_q <= next;
                     if (HANDOFF_CYCLES == 0) begin
                        gnt_q   <= next_oh;
                        state_q <= ARB_OWN;
                     end else begin
                        gnt_q   <= '0;
                        gap_q   <= GAP_LOAD;
                        state_q <= ARB_GAP;
                     end
                  end
               end
               ARB_GAP: begin
                  if (gap_q != '0) gap_q <= gap_q - HW'(1);
                  else if (keep) begin
                     gnt_q   <= owner_oh;
                     state_q <= ARB_OWN;
                  end else begin
                     // New owner vanished during the gap: re-pick and grant without a second gap.
                     owner_q <= next;
                     msel_q  <= next;
                     gnt_q   <= next_oh;
                     if (next != PARK) rr_q <= next;
                     state_q <= ARB_OWN;
                  end
               end
               default: state_q <= ARB_OWN;
            endcase
         end
      end
      assign arb_io.gnt     = gnt_q;
      assign arb_io.msel    = msel_q;
      assign arb_io.owner   = owner_q;
      assign arb_io.rel_req = rel_q;
   end
endmodule
